pll_lock_reset_seq: RTL and testbench

Parametrised clock-domain bring-up block that sits beside the system PLL wrapper in `q_sys`. It drives the PLL reset and filters the PLL `locked` flag. It releases `NUM_CH` downstream reset domains in staged order, and detects loss of lock. On failed lock attempts it retries the PLL up to a bounded count, then latches a sticky failure.

---
 rtl/pll_lock_reset_seq.sv | 202 ++++++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, filters the synchronised lock
// flag, releases NUM_CH reset domains in staged order, counts lock losses and
// retries the PLL a bounded number of times before latching a sticky failure.
// Ports:
//   refclk        free-running reference clock
//   rst_n         asynchronous active-low reset
//   pll_locked    PLL lock flag (asynchronous to refclk)
//   clear_fail    single-cycle pulse, leaves FAIL
//   ch_hold       per-channel software hold (channel kept in reset while high)
//   pll_rst       active-high PLL reset
//   ch_reset_n    active-low channel resets
//   all_ready     RUN with no channel held
//   fail          sticky failure flag
//   lost_lock_cnt saturating count of lock losses after release
module pll_lock_reset_seq #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned PLL_RST_PULSE  = 8,
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned RELOCK_TIMEOUT = 65536,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              clear_fail,
    input  logic [NUM_CH-1:0] ch_hold,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_reset_n,
    output logic              all_ready,
    output logic              fail,
    output logic [7:0]        lost_lock_cnt
);

    // One shared counter serves the reset pulse, the lock timeout and the release slots.
    localparam int unsigned REL_SPAN  = (NUM_CH - 1) * STAGE_GAP + 1;
    localparam int unsigned CNT_MAX_A = (PLL_RST_PULSE > RELOCK_TIMEOUT) ? PLL_RST_PULSE : RELOCK_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > REL_SPAN) ? CNT_MAX_A : REL_SPAN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned FILT_W    = $clog2(LOCK_FILTER + 1);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 1);
    localparam int unsigned LAST_SLOT = (NUM_CH - 1) * STAGE_GAP;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } state_e;

    logic lock_meta_q;
    logic lock_s_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RETRY_W-1:0]  retry_inc;
    logic                pll_rst_q, pll_rst_d;
    logic [NUM_CH-1:0]   ch_reset_n_q, ch_reset_n_d;
    logic                all_ready_q, all_ready_d;
    logic                fail_q, fail_d;
    logic [7:0]          lost_lock_cnt_q, lost_lock_cnt_d;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_PLL_RST;
            cnt_q           <= '0;
            filt_q          <= '0;
            retry_q         <= '0;
            pll_rst_q       <= 1'b1;
            ch_reset_n_q    <= '0;
            all_ready_q     <= 1'b0;
            fail_q          <= 1'b0;
            lost_lock_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            filt_q          <= filt_d;
            retry_q         <= retry_d;
            pll_rst_q       <= pll_rst_d;
            ch_reset_n_q    <= ch_reset_n_d;
            all_ready_q     <= all_ready_d;
            fail_q          <= fail_d;
            lost_lock_cnt_q <= lost_lock_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        filt_d          = filt_q;
        retry_d         = retry_q;
        retry_inc       = retry_q + RETRY_W'(1);
        pll_rst_d       = 1'b0;
        ch_reset_n_d    = '0;
        all_ready_d     = 1'b0;
        fail_d          = 1'b0;
        lost_lock_cnt_d = lost_lock_cnt_q;

        case (state_q)
            ST_PLL_RST: begin
                pll_rst_d = 1'b1;
                filt_d    = '0;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PLL_RST_PULSE - 1)) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end
            end

            ST_WAIT_LOCK: begin
                filt_d = lock_s_q ? filt_q + FILT_W'(1) : '0;
                cnt_d  = cnt_q + CNT_W'(1);
                // Filter completion takes priority over a simultaneous timeout.
                if (lock_s_q && (filt_q == FILT_W'(LOCK_FILTER - 1))) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(RELOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d   = ST_PLL_RST;
                        pll_rst_d = 1'b1;
                    end
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!lock_s_q) begin
                    // Lock lost: drop every channel and restart the PLL.
                    state_d   = ST_PLL_RST;
                    cnt_d     = '0;
                    filt_d    = '0;
                    pll_rst_d = 1'b1;
                    if (lost_lock_cnt_q != 8'hFF) begin
                        lost_lock_cnt_d = lost_lock_cnt_q + 8'd1;
                    end
                end else if (state_q == ST_RUN) begin
                    ch_reset_n_d = ~ch_hold;
                    all_ready_d  = ~|ch_hold;
                end else begin
                    // Channel k opens once its slot k*STAGE_GAP has been reached.
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (cnt_q >= CNT_W'(k * STAGE_GAP)) begin
                            ch_reset_n_d[k] = ~ch_hold[k];
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST_SLOT)) begin
                        state_d     = ST_RUN;
                        cnt_d       = '0;
                        retry_d     = '0;
                        all_ready_d = ~|ch_hold;
                    end
                end
            end

            ST_FAIL: begin
                fail_d = 1'b1;
                if (clear_fail) begin
                    state_d   = ST_PLL_RST;
                    cnt_d     = '0;
                    retry_d   = '0;
                    fail_d    = 1'b0;
                    pll_rst_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_PLL_RST;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
            end
        endcase
    end

    assign pll_rst       = pll_rst_q;
    assign ch_reset_n    = ch_reset_n_q;
    assign all_ready     = all_ready_q;
    assign fail          = fail_q;
    assign lost_lock_cnt = lost_lock_cnt_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: a randomized stimulus plan (lock waveform,
// holds, clear pulses, resets) is laid out per clock edge, a timeline model
// derives the expected output vector for every cycle, each expected change is
// queued as the stimulus for that cycle is applied, and a monitor pops an
// entry whenever the DUT outputs change.
module tb_pll_lock_reset_seq;

    localparam int NCH = 4;
    localparam int P   = 3;
    localparam int LF  = 8;
    localparam int TO  = 64;
    localparam int G   = 4;
    localparam int MR  = 2;
    localparam int H   = 520;
    localparam int ARR = H + 100;

    // Output vector layout: {pll_rst, ch_reset_n[3:0], all_ready, fail, lost_lock_cnt[7:0]}
    localparam logic [14:0] RST_OBS = {1'b1, 14'd0};

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       clear_fail;
    logic [3:0] ch_hold;
    logic       pll_rst;
    logic [3:0] ch_reset_n;
    logic       all_ready;
    logic       fail;
    logic [7:0] lost_lock_cnt;

    pll_lock_reset_seq #(
        .NUM_CH         (NCH),
        .PLL_RST_PULSE  (P),
        .LOCK_FILTER    (LF),
        .RELOCK_TIMEOUT (TO),
        .STAGE_GAP      (G),
        .MAX_RETRY      (MR)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .clear_fail    (clear_fail),
        .ch_hold       (ch_hold),
        .pll_rst       (pll_rst),
        .ch_reset_n    (ch_reset_n),
        .all_ready     (all_ready),
        .fail          (fail),
        .lost_lock_cnt (lost_lock_cnt)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    // Plan arrays are indexed by the clock edge that samples the value.
    bit          lk   [0:ARR];
    logic [3:0]  hold [0:ARR];
    bit          clr  [0:ARR];
    bit          rstv [0:ARR];
    logic [14:0] expv [0:ARR];

    typedef struct {
        int          cyc;
        logic [14:0] v;
    } ev_t;
    ev_t q[$];

    int checks   = 0;
    int failures = 0;

    function automatic logic [14:0] mk(bit pr, logic [3:0] ch, bit ar, bit fl, int lost);
        return {pr, ch, ar, fl, 8'(lost)};
    endfunction

    function automatic logic [14:0] obs_now();
        return {pll_rst, ch_reset_n, all_ready, fail, lost_lock_cnt};
    endfunction

    // Synchronised lock seen by the decision at edge e, for a segment released at s.
    function automatic bit ls(int e, int s);
        return (e - 2 >= s + 1) ? lk[e-2] : 1'b0;
    endfunction

    // Expected outputs from reset release (drive cycle s) up to edge b.
    function automatic void fill_seg(int s, int b);
        int t, w, f, run, tr, lost, retry, loss, cf, last;
        logic [3:0] ch;
        bit ar;
        t = s; lost = 0; retry = 0;
        while (t <= b) begin
            for (int e = t; e <= t + P - 1 && e <= b; e++) expv[e] = mk(1, 4'd0, 0, 0, lost);
            w = t + P;
            f = -1; run = 0;
            for (int e = w + 1; e <= w + TO; e++) begin
                run = ls(e, s) ? run + 1 : 0;
                if (run == LF) begin f = e; break; end
            end
            if (f < 0) begin
                tr = w + TO;
                for (int e = w; e <= tr - 1 && e <= b; e++) expv[e] = mk(0, 4'd0, 0, 0, lost);
                retry++;
                if (retry == MR) begin
                    cf = -1;
                    for (int e = tr + 1; e <= b; e++) if (clr[e]) begin cf = e; break; end
                    last = (cf < 0) ? b : cf - 1;
                    for (int e = tr; e <= last; e++) expv[e] = mk(0, 4'd0, 0, 1, lost);
                    if (cf < 0) return;
                    retry = 0;
                    t = cf;
                end else begin
                    t = tr;
                end
            end else begin
                for (int e = w; e <= f && e <= b; e++) expv[e] = mk(0, 4'd0, 0, 0, lost);
                loss = b + 1;
                for (int e = f + 1; e <= b; e++) if (!ls(e, s)) begin loss = e; break; end
                for (int e = f + 1; e < loss; e++) begin
                    ch = 4'd0;
                    for (int k = 0; k < NCH; k++) if (e >= f + 1 + k * G) ch[k] = ~hold[e][k];
                    ar = (e >= f + 1 + (NCH - 1) * G) && (hold[e] == 4'd0);
                    expv[e] = mk(0, ch, ar, 0, lost);
                end
                if (loss > b) return;
                if (loss > f + 1 + (NCH - 1) * G) retry = 0;
                if (lost < 255) lost++;
                t = loss;
            end
        end
    endfunction

    task automatic build_plan();
        int t1, d, hend, g, cf, rc;
        for (int e = 0; e <= ARR; e++) begin
            lk[e] = 0; hold[e] = 4'd0; clr[e] = 0; rstv[e] = 1; expv[e] = RST_OBS;
        end
        for (int e = 0; e <= 3; e++) rstv[e] = 0;
        // Clean bring-up, then a 2-cycle lock drop in RUN.
        t1 = 8 + int'($urandom % 10);
        for (int e = t1; e <= 119; e++) lk[e] = 1;
        d = 62 + int'($urandom % 6);
        lk[d] = 0; lk[d+1] = 0;
        clr[58] = 1;
        // Channel 2 held across the re-release, dropped in RUN.
        hend = 100 + int'($urandom % 5);
        for (int e = 72; e <= hend; e++) hold[e] = 4'b0100;
        // Long loss then glitchy relock: 5 high, 1 low, then high.
        g = 132 + int'($urandom % 6);
        for (int e = g; e <= g + 4; e++) lk[e] = 1;
        for (int e = g + 6; e <= 199; e++) lk[e] = 1;
        for (int e = 170; e <= 177; e++) hold[e] = 4'($urandom % 16);
        // Lock held low: two failed attempts, FAIL, then clear_fail.
        clr[230] = 1;
        cf = 360 + int'($urandom % 10);
        clr[cf] = 1;
        for (int e = 380; e <= ARR; e++) lk[e] = 1;
        // Reset pulse in the middle of the staged release.
        rc = 394 + int'($urandom % 4);
        for (int e = rc + 1; e <= rc + 5; e++) rstv[e] = 0;
    endtask

    task automatic build_model();
        int e, a;
        e = 1;
        while (e <= H) begin
            if (!rstv[e]) begin
                e++;
            end else begin
                a = e;
                while (e <= H && rstv[e]) e++;
                fill_seg(a - 1, e - 1);
            end
        end
    endtask

    // Monitor: every output change must match the next queued expectation.
    logic [14:0] mon_prev = RST_OBS;
    always @(negedge refclk) begin
        logic [14:0] o;
        ev_t ent;
        o = obs_now();
        if (o !== mon_prev) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, o);
            end else begin
                ent = q.pop_front();
                if (ent.cyc != cyc || ent.v !== o) begin
                    failures++;
                    $display("FAIL output_change cyc=%0d got=%h required=%h at_cyc=%0d",
                             cyc, o, ent.v, ent.cyc);
                end
            end
        end
        mon_prev = o;
    end

    initial begin
        int c;
        ev_t ent;
        rst_n = 1'b0; pll_locked = 1'b0; clear_fail = 1'b0; ch_hold = 4'd0;
        build_plan();
        build_model();
        @(negedge refclk);
        while (cyc < H) begin
            c = cyc;
            #1;
            if (c == 2) begin
                checks++;
                if (obs_now() !== RST_OBS) begin
                    failures++;
                    $display("FAIL reset_values got=%h required=%h", obs_now(), RST_OBS);
                end
            end
            rst_n      = rstv[c+1];
            pll_locked = lk[c+1];
            clear_fail = clr[c+1];
            ch_hold    = hold[c+1];
            if (rstv[c] && !rstv[c+1]) begin
                #1;
                checks++;
                if (obs_now() !== RST_OBS) begin
                    failures++;
                    $display("FAIL async_reset cyc=%0d got=%h required=%h", c, obs_now(), RST_OBS);
                end
            end
            if (expv[c+1] !== expv[c]) begin
                ent.cyc = c + 1;
                ent.v   = expv[c+1];
                q.push_back(ent);
            end
            @(negedge refclk);
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_changes got=%0d required=0 next_cyc=%0d", q.size(), q[0].cyc);
        end
        checks++;
        if (obs_now() !== expv[H]) begin
            failures++;
            $display("FAIL final_state got=%h required=%h", obs_now(), expv[H]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
